sincos_arbiter: RTL and testbench
=================================

Name: sincos_arbiter

Overview:
- Shares one sine_table lookup port between NUM_REQ requesters.
- Each request is one angle index. The block performs two table reads: sine at the angle, then cosine as the sine at angle+90°. It returns both float32 values to the requester in a single response.
- Sits between the rotation/projection control logic and the single sine table instance in the control datapath.

Parameters:
- NUM_REQ, 4, number of requesters (≥2).
- BRAM_DEPTH, 1024, table entries per quadrant; a full circle is 4*BRAM_DEPTH.
- ADDRW, $clog2(4*BRAM_DEPTH), angle/table index width.
- DATA_W, 32, table data width (float32).
- LOOKUP_LAT, 2, cycles from tab_id driven to matching tab_data valid.

Ports:
- clk_in, input, 1, clock.
- rst_in, input, 1, asynchronous active-high reset.
- req_valid, input, NUM_REQ, per-requester request valid.
- req_angle, input, NUM_REQ*ADDRW, packed angles; requester i uses bits [i*ADDRW +: ADDRW].
- req_ready, output, NUM_REQ, one-hot grant; a transfer occurs on valid&ready.
- rsp_valid, output, NUM_REQ, one-hot single-cycle response strobe.
- rsp_sin, output, DATA_W, sine result (shared bus).
- rsp_cos, output, DATA_W, cosine result (shared bus).
- tab_id, output, ADDRW, index to sine table.
- tab_data, input, DATA_W, sine table output.
- busy, output, 1, high in any state other than IDLE.

Behaviour:
- Reset (async, active-high):
  - State=IDLE.
  - req_ready, rsp_valid, tab_id, rsp_sin, rsp_cos = 0.
  - busy=0.
  - Round-robin pointer = NUM_REQ-1, so requester 0 wins first.
- State machine: IDLE → ISSUE_SIN → ISSUE_COS → WAIT → RESPOND → IDLE.
- IDLE:
  - Combinational round-robin search starting at pointer+1 (mod NUM_REQ).
  - The first requester with req_valid=1 gets req_ready=1 in the same cycle.
  - The block latches the angle and one-hot owner, updates pointer=winner, and moves to ISSUE_SIN.
  - No valid requests: stay in IDLE, req_ready=0.
- Requester rules: hold req_valid and req_angle stable until granted. req_ready is never asserted outside IDLE.
- ISSUE_SIN (1 cycle): tab_id = latched angle.
- ISSUE_COS (1 cycle):
  - tab_id = (angle + BRAM_DEPTH) truncated to ADDRW bits, i.e. wraps mod 4*BRAM_DEPTH.
  - Example: 3500 → 428 at default parameters.
- WAIT:
  - A down-counter captures tab_data into sin_reg exactly LOOKUP_LAT cycles after ISSUE_SIN, and into cos_reg LOOKUP_LAT cycles after ISSUE_COS.
  - Leaves for RESPOND on the cycle after the cos capture.
- tab_id is held at the last driven value outside the ISSUE states.
- RESPOND (1 cycle):
  - rsp_valid = owner one-hot; rsp_sin/rsp_cos = captured registers.
  - No response backpressure; the requester must sample in this cycle.
  - rsp_sin/rsp_cos hold their values until the next RESPOND.
- Latency: grant cycle to rsp_valid = LOOKUP_LAT+3 cycles (5 at default).
  - IDLE is re-entered after RESPOND, so the next grant can occur one cycle after the response.
  - Sustained throughput: one request per LOOKUP_LAT+4 cycles.
- Fairness: a requester granted last cannot win again while any other requester is valid.
- Reset mid-operation: the in-flight request is dropped with no rsp_valid. The requester must re-issue.
- Simultaneous grant and response cannot occur; the FSM is single-outstanding.
- Reset-state tab_id=0 is harmless; table output is ignored outside capture cycles.

Optional Feature:
- Macro: SINCOS_ARB_PERF_CNT_EN.
- Defined:
  - Adds output resp_cnt, 16 bits.
  - Increments by 1 on every RESPOND cycle, saturating at 16'hFFFF.
  - Reset to 0 by rst_in.
- Undefined:
  - Port and counter are absent.
  - All other behaviour is identical.

Test Plan:
- Req0 angle 0, others idle:
  - req_ready[0] pulses in the grant cycle.
  - tab_id=0, then tab_id=1024.
  - rsp_valid=4'b0001 at grant+5.
  - rsp_sin=0x00000000, rsp_cos=0x3F800000.
- Req2 angle 3500:
  - Cos lookup tab_id=428.
  - rsp_sin/rsp_cos equal the model table values at 3500 and 428.
  - rsp_valid=4'b0100.
- All four valid from reset, held:
  - Grants in order 0,1,2,3, spaced 6 cycles apart.
  - Each rsp_valid one-hot matches its grant owner.
- Req1 and req3 continuously valid:
  - Grants alternate 1,3,1,3; req1 is never granted twice in a row.
- rst_in asserted during WAIT:
  - Outputs zero immediately (asynchronous).
  - No rsp_valid for the dropped request.
  - After release, the next grant goes to req0 if valid.
- With SINCOS_ARB_PERF_CNT_EN defined:
  - 3 completed requests → resp_cnt=3.
  - Force counter to 16'hFFFE, complete 2 requests → resp_cnt=16'hFFFF.

Source files
------------

// File: rtl/sincos_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sincos_arbiter
// Description : Round-robin arbiter sharing one sine-table port among NUM_REQ
//               requesters; each request returns sin(a) and sin(a+90deg).
//               Optional `SINCOS_ARB_PERF_CNT_EN adds a saturating response
//               counter output (resp_cnt).
// Revision    : 1.0 - initial release
// ============================================================================
module sincos_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int BRAM_DEPTH = 1024,
    parameter int ADDRW      = $clog2(4 * BRAM_DEPTH),
    parameter int DATA_W     = 32,
    parameter int LOOKUP_LAT = 2
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*ADDRW-1:0] req_angle,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [NUM_REQ-1:0]       rsp_valid,
    output logic [DATA_W-1:0]        rsp_sin,
    output logic [DATA_W-1:0]        rsp_cos,
    output logic [ADDRW-1:0]         tab_id,
    input  logic [DATA_W-1:0]        tab_data,
    output logic                     busy
`ifdef SINCOS_ARB_PERF_CNT_EN
    ,
    output logic [15:0]              resp_cnt
`endif
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(LOOKUP_LAT + 2);

    localparam logic [2:0] c_st_idle      = 3'd0;
    localparam logic [2:0] c_st_issue_sin = 3'd1;
    localparam logic [2:0] c_st_issue_cos = 3'd2;
    localparam logic [2:0] c_st_wait      = 3'd3;
    localparam logic [2:0] c_st_respond   = 3'd4;

    localparam logic [ADDRW-1:0] c_quarter  = ADDRW'(BRAM_DEPTH);
    localparam logic [CNT_W-1:0] c_cnt_load = CNT_W'(LOOKUP_LAT + 1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    logic [2:0]         r_state;
    logic [PTR_W-1:0]   r_ptr;
    logic [NUM_REQ-1:0] r_owner;
    logic [ADDRW-1:0]   r_angle;
    logic [ADDRW-1:0]   r_tab_id;
    logic [CNT_W-1:0]   r_cnt;
    logic [DATA_W-1:0]  r_sin;
    logic [DATA_W-1:0]  r_rsp_sin;
    logic [DATA_W-1:0]  r_rsp_cos;

    logic [NUM_REQ-1:0] w_grant;
    logic               w_found;
    logic [PTR_W-1:0]   w_win;
    logic [ADDRW-1:0]   w_win_angle;

    // Search order starts one past the last winner, so the previous owner is
    // only reconsidered after every other requester has been passed over.
    always_comb begin
        w_grant     = '0;
        w_found     = 1'b0;
        w_win       = r_ptr;
        w_win_angle = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!w_found && req_valid[j] && (j == ((int'(r_ptr) + k) % NUM_REQ))) begin
                    w_grant[j] = 1'b1;
                    w_found    = 1'b1;
                    w_win      = PTR_W'(j);
                end
            end
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            if (w_grant[j]) begin
                w_win_angle = req_angle[j*ADDRW +: ADDRW];
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state   <= c_st_idle;
            r_ptr     <= PTR_W'(NUM_REQ - 1);
            r_owner   <= '0;
            r_angle   <= '0;
            r_tab_id  <= '0;
            r_cnt     <= '0;
            r_sin     <= '0;
            r_rsp_sin <= '0;
            r_rsp_cos <= '0;
        end else begin
            // r_cnt reads LOOKUP_LAT+1 in the sine-issue cycle: sine data is
            // on tab_data when it reaches 1, cosine data when it reaches 0.
            if (r_state != c_st_idle && r_cnt != '0) begin
                r_cnt <= r_cnt - c_cnt_one;
            end
            if ((r_state == c_st_issue_cos || r_state == c_st_wait) && r_cnt == c_cnt_one) begin
                r_sin <= tab_data;
            end

            case (r_state)
                c_st_idle: begin
                    if (w_found) begin
                        r_owner  <= w_grant;
                        r_angle  <= w_win_angle;
                        r_ptr    <= w_win;
                        r_tab_id <= w_win_angle;
                        r_cnt    <= c_cnt_load;
                        r_state  <= c_st_issue_sin;
                    end
                end
                c_st_issue_sin: begin
                    r_tab_id <= r_angle + c_quarter;
                    r_state  <= c_st_issue_cos;
                end
                c_st_issue_cos: begin
                    r_state <= c_st_wait;
                end
                c_st_wait: begin
                    if (r_cnt == '0) begin
                        r_rsp_sin <= r_sin;
                        r_rsp_cos <= tab_data;
                        r_state   <= c_st_respond;
                    end
                end
                c_st_respond: begin
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign req_ready = (r_state == c_st_idle)    ? w_grant : '0;
    assign rsp_valid = (r_state == c_st_respond) ? r_owner : '0;
    assign rsp_sin   = r_rsp_sin;
    assign rsp_cos   = r_rsp_cos;
    assign tab_id    = r_tab_id;
    assign busy      = (r_state != c_st_idle);

`ifdef SINCOS_ARB_PERF_CNT_EN
    logic [15:0] r_resp_cnt;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_resp_cnt <= '0;
        end else if (r_state == c_st_respond && r_resp_cnt != 16'hFFFF) begin
            r_resp_cnt <= r_resp_cnt + 16'd1;
        end
    end

    assign resp_cnt = r_resp_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sincos_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sincos_arbiter
// Description : Directed self-checking bench for sincos_arbiter with a
//               two-cycle model sine table.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sincos_arbiter;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [47:0] req_angle = '0;
    logic [3:0]  req_ready;
    logic [3:0]  rsp_valid;
    logic [31:0] rsp_sin;
    logic [31:0] rsp_cos;
    logic [11:0] tab_id;
    logic [31:0] tab_data = '0;
    logic        busy;
`ifdef SINCOS_ARB_PERF_CNT_EN
    logic [15:0] resp_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    sincos_arbiter dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .req_valid (req_valid),
        .req_angle (req_angle),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_sin   (rsp_sin),
        .rsp_cos   (rsp_cos),
        .tab_id    (tab_id),
        .tab_data  (tab_data),
        .busy      (busy)
`ifdef SINCOS_ARB_PERF_CNT_EN
        ,
        .resp_cnt  (resp_cnt)
`endif
    );

    always #5 clk_in = ~clk_in;

    // Model table: exact values at the quadrant points, tagged index elsewhere.
    function automatic logic [31:0] tab_model(input logic [11:0] id);
        case (id)
            12'd0:    return 32'h0000_0000;
            12'd1024: return 32'h3F80_0000;
            12'd2048: return 32'h0000_0000;
            12'd3072: return 32'hBF80_0000;
            default:  return 32'hA500_0000 | {20'd0, id};
        endcase
    endfunction

    logic [31:0] r_tab_d1 = '0;
    always @(posedge clk_in) begin
        r_tab_d1 <= tab_model(tab_id);
        tab_data <= r_tab_d1;
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // One isolated request from requester idx; DUT must be idle on entry.
    task automatic run_one(input int idx, input logic [11:0] ang, input logic [11:0] cos_id,
                           input logic [31:0] es, input logic [31:0] ec);
        logic [3:0] oh;
        oh = 4'b0001 << idx;
        req_angle[idx*12 +: 12] = ang;
        req_valid = oh;
        #1;
        chk("grant", req_ready, oh);
        tick();
        req_valid = '0;
        chk("busy_issue", busy, 1);
        chk("ready_low", req_ready, 0);
        chk("tab_sin_id", tab_id, ang);
        tick();
        chk("tab_cos_id", tab_id, cos_id);
        tick();
        tick();
        chk("no_early_rsp", rsp_valid, 0);
        tick();
        chk("rsp_valid", rsp_valid, oh);
        chk("rsp_sin", rsp_sin, es);
        chk("rsp_cos", rsp_cos, ec);
        tick();
        chk("rsp_done", rsp_valid, 0);
        chk("idle", busy, 0);
    endtask

    task automatic reset_pulse();
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_sin [4];
        logic [31:0] exp_cos [4];
        int gcyc [4];
        int ng;
        int nr;
        int seen;

        tick();
        tick();
        chk("rst_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_tab_id", tab_id, 0);
        chk("rst_sin", rsp_sin, 0);
        chk("rst_cos", rsp_cos, 0);
        chk("rst_busy", busy, 0);
        rst_in = 1'b0;

        run_one(0, 12'd0, 12'd1024, 32'h0000_0000, 32'h3F80_0000);
        run_one(2, 12'd3500, 12'd428, 32'hA500_0DAC, 32'hA500_01AC);

        // All four requesters held valid from reset.
        exp_sin = '{32'hA500_0064, 32'hA500_00C8, 32'hA500_012C, 32'hA500_0FA0};
        exp_cos = '{32'hA500_0464, 32'hA500_04C8, 32'hA500_052C, 32'hA500_03A0};
        reset_pulse();
        req_angle = {12'd4000, 12'd300, 12'd200, 12'd100};
        req_valid = 4'hF;
        #1;
        ng = 0;
        nr = 0;
        for (int c = 0; c < 24; c++) begin
            if (req_ready != 4'b0000) begin
                if (ng < 4) begin
                    chk("grant_order", req_ready, 4'b0001 << ng);
                    if (ng > 0) chk("grant_gap", c - gcyc[ng-1], 6);
                    gcyc[ng] = c;
                end
                ng++;
            end
            if (rsp_valid != 4'b0000) begin
                if (nr < 4 && nr < ng) begin
                    chk("rsp_owner", rsp_valid, 4'b0001 << nr);
                    chk("rsp_latency", c - gcyc[nr], 5);
                    chk("rsp_sin_all", rsp_sin, exp_sin[nr]);
                    chk("rsp_cos_all", rsp_cos, exp_cos[nr]);
                end
                nr++;
            end
            tick();
        end
        chk("grant_count", ng, 4);
        chk("rsp_count", nr, 4);

        // Requesters 1 and 3 contend continuously.
        reset_pulse();
        req_valid = 4'b1010;
        #1;
        ng = 0;
        for (int c = 0; c < 24; c++) begin
            if (req_ready != 4'b0000) begin
                chk("rr_alternate", req_ready, (ng % 2 == 0) ? 4'b0010 : 4'b1000);
                ng++;
            end
            tick();
        end
        chk("rr_count", ng, 4);

        // Asynchronous reset while a lookup is in flight.
        req_valid = '0;
        reset_pulse();
        req_angle[11:0] = 12'd5;
        req_valid = 4'b0001;
        #1;
        chk("mid_grant", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        tick();
        tick();
        chk("mid_busy", busy, 1);
        rst_in = 1'b1;
        #1;
        chk("async_busy", busy, 0);
        chk("async_tab_id", tab_id, 0);
        chk("async_rsp_valid", rsp_valid, 0);
        chk("async_sin", rsp_sin, 0);
        chk("async_cos", rsp_cos, 0);
        tick();
        rst_in = 1'b0;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            if (rsp_valid != 4'b0000) seen++;
            tick();
        end
        chk("dropped_no_rsp", seen, 0);
        req_angle[35:24] = 12'd7;
        req_valid = 4'b0101;
        #1;
        chk("post_rst_grant", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        for (int c = 0; c < 6; c++) tick();

`ifdef SINCOS_ARB_PERF_CNT_EN
        reset_pulse();
        chk("cnt_reset", resp_cnt, 0);
        for (int n = 0; n < 3; n++) run_one(1, 12'd10, 12'd1034, 32'hA500_000A, 32'hA500_040A);
        chk("cnt_three", resp_cnt, 3);
        dut.r_resp_cnt = 16'hFFFE;
        for (int n = 0; n < 2; n++) run_one(1, 12'd10, 12'd1034, 32'hA500_000A, 32'hA500_040A);
        chk("cnt_saturate", resp_cnt, 16'hFFFF);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
